sram_test_sequencer: RTL and testbench

- Schedules one or more simple SRAM R/W tester instances, one per SRAM device.
- Enables each tester in turn for a programmed dwell time and collects its pass/fail flags into sticky per-device results.
- Repeats the sweep for a programmed loop count, or forever.
- Sits between the board-test register block (start, abort, configuration in; results out) and the tester instances.

---
 rtl/sram_test_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sram_test_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_test_sequencer.sv
// Sweeps a bank of SRAM R/W testers: enables each in turn for a dwell and collects
// sticky pass/fail results. Repeats for a programmed number of sweeps, or until aborted.
module sram_test_sequencer #(
  parameter int pNUM_SRAM    = 2,
  parameter int pDWELL_WIDTH = 32,
  parameter int pGAP         = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    I_start,
  input  logic                    I_abort,
  input  logic                    I_stop_on_fail,
  input  logic [pNUM_SRAM-1:0]    I_enable_mask,
  input  logic [pDWELL_WIDTH-1:0] I_dwell,
  input  logic [15:0]             I_loops,
  input  logic [pNUM_SRAM-1:0]    I_pass,
  input  logic [pNUM_SRAM-1:0]    I_fail,
  output logic [pNUM_SRAM-1:0]    O_active,
  output logic [pNUM_SRAM-1:0]    O_pass,
  output logic [pNUM_SRAM-1:0]    O_fail,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_aborted,
  output logic [2:0]              O_current,
  output logic [15:0]             O_loop_count
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_GAP = 2'd2, ST_DONE = 2'd3} state_t;
  localparam logic [pDWELL_WIDTH-1:0] LP_GAP_LAST = pDWELL_WIDTH'(pGAP - 1);

  state_t                  r_state, w_state_nxt;
  logic [pDWELL_WIDTH-1:0] r_timer, w_timer_nxt, w_dwell_last;
  logic [2:0]              r_idx, w_idx_nxt, w_lowest, w_next;
  logic                    w_any_en, w_next_found, w_cur_fail, w_cur_pass;
  logic [pNUM_SRAM-1:0]    r_active, w_active_nxt, r_pass, w_pass_nxt;
  logic [pNUM_SRAM-1:0]    r_fail, w_fail_nxt, w_idx_oh;
  logic                    r_aborted, w_aborted_nxt;
  logic [15:0]             r_loop_count, w_loop_nxt, w_loop_inc;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    w_lowest     = '0;
    w_next       = '0;
    w_next_found = 1'b0;
    w_idx_oh     = '0;
    for (int i = pNUM_SRAM - 1; i >= 0; i--) begin
      if (I_enable_mask[i]) w_lowest = 3'(i);
      if (I_enable_mask[i] && (3'(i) > r_idx)) begin
        w_next       = 3'(i);
        w_next_found = 1'b1;
      end
      w_idx_oh[i] = (r_idx == 3'(i));
    end
  end

  assign w_any_en     = |I_enable_mask;
  assign w_cur_fail   = |(I_fail & w_idx_oh);
  assign w_cur_pass   = |(I_pass & w_idx_oh);
  assign w_dwell_last = (I_dwell == '0) ? '0 : I_dwell - pDWELL_WIDTH'(1);
  assign w_loop_inc   = (&r_loop_count) ? r_loop_count : r_loop_count + 16'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_idx_nxt     = r_idx;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_aborted_nxt = r_aborted;
    w_loop_nxt    = r_loop_count;
    case (r_state)
      ST_IDLE: begin
        if (I_start) begin
          w_pass_nxt    = '0;
          w_fail_nxt    = '0;
          w_aborted_nxt = 1'b0;
          w_loop_nxt    = '0;
          w_timer_nxt   = '0;
          if (w_any_en) begin
            w_idx_nxt   = w_lowest;
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (I_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end else begin
          if (w_cur_fail) begin
            w_fail_nxt = r_fail | w_idx_oh;
            w_pass_nxt = r_pass & ~w_idx_oh;
          end
          if (w_cur_fail && I_stop_on_fail) begin
            w_aborted_nxt = 1'b1;
            w_state_nxt   = ST_DONE;
          end else if (r_timer == w_dwell_last) begin
            // A fail on the final dwell cycle already blocks the pass here.
            if (w_cur_pass && !(|(w_fail_nxt & w_idx_oh))) w_pass_nxt = w_pass_nxt | w_idx_oh;
            w_timer_nxt = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_timer_nxt = r_timer + pDWELL_WIDTH'(1);
          end
        end
      end
      ST_GAP: begin
        if (I_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end else if (r_timer == LP_GAP_LAST) begin
          w_timer_nxt = '0;
          if (w_next_found) begin
            w_idx_nxt   = w_next;
            w_state_nxt = ST_RUN;
          end else begin
            w_loop_nxt = w_loop_inc;
            if ((I_loops != 16'd0) && (w_loop_inc >= I_loops)) begin
              w_state_nxt = ST_DONE;
            end else if (w_any_en) begin
              w_idx_nxt   = w_lowest;
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end else begin
          w_timer_nxt = r_timer + pDWELL_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (!I_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active_nxt = '0;
    for (int i = 0; i < pNUM_SRAM; i++)
      w_active_nxt[i] = (w_state_nxt == ST_RUN) && (w_idx_nxt == 3'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer      <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_aborted    <= 1'b0;
      r_loop_count <= '0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_idx        <= w_idx_nxt;
      r_active     <= w_active_nxt;
      r_pass       <= w_pass_nxt;
      r_fail       <= w_fail_nxt;
      r_aborted    <= w_aborted_nxt;
      r_loop_count <= w_loop_nxt;
    end
  end

  assign O_active     = r_active;
  assign O_pass       = r_pass;
  assign O_fail       = r_fail;
  assign O_busy       = (r_state == ST_RUN) || (r_state == ST_GAP);
  assign O_done       = (r_state == ST_DONE);
  assign O_aborted    = r_aborted;
  assign O_current    = r_idx;
  assign O_loop_count = r_loop_count;
endmodule

// File: tb/tb_sram_test_sequencer.sv
// Scoreboarded bench: a sweep-level model queues expected dwells and final results;
// a monitor measures active windows, gaps and end-of-run results and compares.
module tb_sram_test_sequencer;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int GAP = 4;

  logic          clk, reset_n;
  logic          I_start, I_abort, I_stop_on_fail;
  logic [N-1:0]  I_enable_mask, I_pass, I_fail;
  logic [DW-1:0] I_dwell;
  logic [15:0]   I_loops;
  logic [N-1:0]  O_active, O_pass, O_fail;
  logic          O_busy, O_done, O_aborted;
  logic [2:0]    O_current;
  logic [15:0]   O_loop_count;

  sram_test_sequencer #(.pNUM_SRAM(N), .pDWELL_WIDTH(DW), .pGAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .I_start(I_start), .I_abort(I_abort),
    .I_stop_on_fail(I_stop_on_fail), .I_enable_mask(I_enable_mask), .I_dwell(I_dwell),
    .I_loops(I_loops), .I_pass(I_pass), .I_fail(I_fail), .O_active(O_active),
    .O_pass(O_pass), .O_fail(O_fail), .O_busy(O_busy), .O_done(O_done),
    .O_aborted(O_aborted), .O_current(O_current), .O_loop_count(O_loop_count));

  typedef struct { int idx; int len; int gap; } seg_t;
  typedef struct { logic [N-1:0] pass; logic [N-1:0] fail; bit ab; int cur; int loops; int gap; } fin_t;

  seg_t sq[$];
  fin_t fq[$];
  int checks = 0, failures = 0;
  int last_cur = 0;
  logic [N-1:0] last_pass = '0;

  // Tester behaviour plan: tester i fails on its dwell fdw[i] at active cycle fc[i].
  int fdw[N], fc[N];
  logic [N-1:0] pv = '0;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: walks sweeps and dwells directly from the rules.
  task automatic model(input logic [N-1:0] m, input int d, input int L, input bit sof,
                       input logic [N-1:0] p, input int abk);
    fin_t f;
    seg_t s;
    int D, nd, gap, sw;
    bit done;
    D = (d == 0) ? 1 : d;
    f.pass = '0; f.fail = '0; f.ab = 0; f.cur = last_cur; f.loops = 0; f.gap = 0;
    nd = 0; gap = 0; done = (m == '0); sw = 0;
    while (!done) begin
      for (int i = 0; i < N; i++) begin
        if (!done && m[i]) begin
          f.cur = i;
          if (fdw[i] == sw && fc[i] < D) begin
            f.fail[i] = 1'b1; f.pass[i] = 1'b0;
            if (sof) begin
              s.idx = i; s.len = fc[i] + 1; s.gap = gap; sq.push_back(s);
              f.ab = 1; f.gap = 0; done = 1;
            end
          end
          if (!done) begin
            if (p[i] && !f.fail[i]) f.pass[i] = 1'b1;
            s.idx = i; s.len = D; s.gap = gap; sq.push_back(s);
            gap = GAP; nd++;
            if (abk != 0 && nd == abk) begin f.ab = 1; f.gap = 1; done = 1; end
          end
        end
      end
      if (!done) begin
        f.loops++;
        if (L != 0 && f.loops >= L) begin done = 1; f.gap = GAP; end
      end
      sw++;
    end
    fq.push_back(f);
    last_cur = f.cur;
    last_pass = f.pass;
  endtask

  // Tester emulation: planned flags while active, junk otherwise (must be ignored).
  initial begin
    int dw[N], cyc[N];
    bit wasact[N];
    for (int i = 0; i < N; i++) begin dw[i] = 0; cyc[i] = 0; wasact[i] = 0; end
    I_pass = '0; I_fail = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!O_busy) dw[i] = 0;
        if (O_active[i]) begin
          cyc[i] = wasact[i] ? cyc[i] + 1 : 0;
          I_fail[i] = (dw[i] == fdw[i]) && (cyc[i] == fc[i]);
          I_pass[i] = pv[i];
        end else begin
          if (wasact[i]) dw[i]++;
          I_fail[i] = 1'($urandom);
          I_pass[i] = 1'($urandom);
        end
        wasact[i] = O_active[i];
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit in_seg, prev_done;
    int seglen, gapcnt, seg_gap, seg_cur;
    logic [N-1:0] seg_act, one;
    seg_t s;
    fin_t f;
    in_seg = 0; prev_done = 0; seglen = 0; gapcnt = 0; seg_gap = 0; seg_cur = 0;
    seg_act = '0; one = 1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_seg = 0; seglen = 0; gapcnt = 0; prev_done = 0;
      end else begin
        if (O_active != '0) begin
          if (!in_seg) begin
            in_seg = 1; seglen = 0; seg_act = O_active; seg_gap = gapcnt; seg_cur = int'(O_current);
          end
          seglen++; gapcnt = 0;
        end else begin
          if (in_seg) begin
            in_seg = 0;
            if (sq.size() == 0) chk("seg_unexpected", 1, 0);
            else begin
              s = sq.pop_front();
              chk("seg_active", seg_act, one << s.idx);
              chk("seg_current", seg_cur, s.idx);
              chk("seg_len", seglen, s.len);
              chk("seg_gap", seg_gap, s.gap);
            end
          end
          if (O_busy) gapcnt++;
        end
        if (O_done && !prev_done) begin
          if (fq.size() == 0) chk("fin_unexpected", 1, 0);
          else begin
            f = fq.pop_front();
            chk("fin_pass", O_pass, f.pass);
            chk("fin_fail", O_fail, f.fail);
            chk("fin_aborted", O_aborted, f.ab);
            chk("fin_current", O_current, f.cur);
            chk("fin_loops", O_loop_count, f.loops);
            chk("fin_gap", gapcnt, f.gap);
            chk("fin_busy_active", {O_busy, O_active}, 0);
          end
          gapcnt = 0;
        end
        prev_done = O_done;
      end
    end
  end

  task automatic no_fails();
    for (int i = 0; i < N; i++) begin fdw[i] = -1; fc[i] = 0; end
  endtask

  task automatic run(input logic [N-1:0] m, input int d, input int L, input bit sof,
                     input logic [N-1:0] p, input int abk, input bit hold);
    int segs, cyc;
    bit prev_act, sent, ok;
    @(negedge clk);
    I_enable_mask = m; I_dwell = DW'(d); I_loops = 16'(L); I_stop_on_fail = sof; pv = p;
    model(m, d, L, sof, p, abk);
    I_start = 1'b1;
    segs = 0; prev_act = 0; sent = 0; ok = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (sent) begin
        I_abort = 1'b0;
        chk("abort_latency", O_done, 1);
      end
      if (O_done) begin ok = 1; break; end
      if (prev_act && O_active == '0) segs++;
      prev_act = (O_active != '0);
      if (abk != 0 && !sent && segs >= abk && O_busy && O_active == '0) begin
        I_abort = 1'b1; sent = 1;
      end
    end
    I_abort = 1'b0;
    if (!ok) chk("run_timeout", 0, 1);
    if (m == '0) chk("mask0_latency", cyc, 0);
    if (hold) begin
      repeat (5) @(negedge clk);
      chk("hold_done", O_done, 1);
      chk("hold_busy", O_busy, 0);
    end
    I_start = 1'b0;
    @(negedge clk);
    if (hold) begin
      chk("rearm_idle", O_done, 0);
      chk("rearm_pass_held", O_pass, last_pass);
    end
  endtask

  initial begin
    int d, L;
    logic [N-1:0] m, p;
    reset_n = 1'b0; I_start = 0; I_abort = 0; I_stop_on_fail = 0;
    I_enable_mask = '0; I_dwell = '0; I_loops = '0;
    no_fails();
    #12;
    chk("rst_outputs", {O_active, O_pass, O_fail, O_busy, O_done, O_aborted, O_current, O_loop_count}, 0);
    @(negedge clk); reset_n = 1'b1;

    run(2'b00, 3, 1, 0, 2'b11, 0, 0);              // empty mask
    run(2'b11, 10, 1, 0, 2'b11, 0, 1);             // basic sweep + hold/rearm
    no_fails(); fdw[1] = 0; fc[1] = 5;
    run(2'b11, 10, 3, 0, 2'b11, 0, 0);             // fail capture
    no_fails(); fdw[0] = 0; fc[0] = 3;
    run(2'b11, 10, 2, 1, 2'b11, 0, 0);             // stop on fail
    no_fails();
    run(2'b10, 0, 2, 0, 2'b10, 0, 0);              // dwell 0
    run(2'b11, 5, 0, 0, 2'b11, 15, 0);             // continuous, abort in gap after 7 sweeps
    no_fails(); fdw[1] = 1; fc[1] = 0;
    run(2'b11, 4, 2, 0, 2'b11, 0, 0);              // fail on first dwell cycle, second sweep
    no_fails(); fdw[0] = 0; fc[0] = 2;
    run(2'b01, 3, 1, 0, 2'b01, 0, 0);              // fail on final dwell cycle blocks pass

    for (int r = 0; r < 14; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      d = $urandom_range(0, 6);
      L = $urandom_range(1, 3);
      p = N'($urandom);
      for (int i = 0; i < N; i++) begin
        fdw[i] = $urandom_range(0, 3);
        fc[i]  = $urandom_range(0, (d == 0) ? 1 : d);
      end
      run(m, d, L, 1'($urandom), p, 0, 0);
    end

    // Asynchronous reset mid-dwell.
    no_fails();
    @(negedge clk);
    I_enable_mask = 2'b10; I_dwell = 32'd20; I_loops = 16'd1; I_stop_on_fail = 0; pv = 2'b10;
    I_start = 1'b1;
    begin
      int w;
      for (w = 0; w < 20; w++) begin @(negedge clk); if (O_active != '0) break; end
      if (w == 20) chk("reset_run_timeout", 0, 1);
    end
    repeat (3) @(negedge clk);
    chk("pre_reset_active", O_active, 2'b10);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {O_active, O_pass, O_fail, O_busy, O_done, O_aborted, O_current, O_loop_count}, 0);
    I_start = 1'b0;
    sq.delete(); fq.delete();
    last_cur = 0;
    @(negedge clk); reset_n = 1'b1;
    run(2'b11, 2, 1, 0, 2'b01, 0, 0);              // recovery after reset

    repeat (3) @(negedge clk);
    chk("seg_queue_empty", sq.size(), 0);
    chk("fin_queue_empty", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
